// File: rtl/spectrum_frame_scheduler_pkg.sv
// +----------------------------------------------------------------------------+
// | Package   : spectrum_pkg                                                   |
// | Purpose   : Shared types, widths and magnitude clamp for the scheduler.    |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package spectrum_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PENDING = 2'd1,
        SWAP    = 2'd2,
        ARMED   = 2'd3
    } sched_state_t;

    localparam int PEAK_W = 9;
    localparam int BIN_W  = 9;

    function automatic logic [PEAK_W-1:0] clamp_mag(input logic [31:0] shifted,
                                                    input int unsigned max_y);
        if (shifted > 32'(max_y - 1))
            return PEAK_W'(max_y - 1);
        return shifted[PEAK_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/peak_bank_ram.sv
// +----------------------------------------------------------------------------+
// | Module    : peak_bank_ram                                                  |
// | Purpose   : Two N_BINS x PEAK_W peak banks, one write port, two registered |
// |             read ports (display read and peak-hold read).                  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module peak_bank_ram
    import spectrum_pkg::*;
#(
    parameter int N_BINS = 512
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [BIN_W-1:0]  wr_addr,
    input  logic [PEAK_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic              rd_en,
    input  logic [BIN_W-1:0]  rd_addr,
    output logic [PEAK_W-1:0] rd_data,
    input  logic [BIN_W-1:0]  hold_addr,
    output logic [PEAK_W-1:0] hold_data
);

    logic [PEAK_W-1:0] r_mem [2][N_BINS];

    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[wr_bank][wr_addr] <= wr_data;
        hold_data <= r_mem[rd_bank][hold_addr];
    end

    // Display read resets to zero and returns zero for off-screen columns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= r_mem[rd_bank][rd_addr];
        else
            rd_data <= '0;
    end

endmodule

`default_nettype wire

// File: rtl/spectrum_frame_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module    : spectrum_frame_scheduler                                       |
// | Purpose   : Double-buffered peak store and frame sequencer for the column  |
// |             line drawer. Optional macro PEAK_HOLD_EN enables decaying hold.|
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module spectrum_frame_scheduler
    import spectrum_pkg::*;
#(
    parameter int N_BINS    = 512,
    parameter int MAG_IN_W  = 16,
    parameter int MAG_SHIFT = 6,
    parameter int MAX_Y     = 480,
    parameter int DECAY     = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [BIN_W-1:0]    wr_bin,
    input  logic [MAG_IN_W-1:0] wr_mag,
    input  logic                wr_last,
    input  logic                draw_state,
    input  logic                clear_state,
    input  logic [9:0]          draw_x,
    output logic [PEAK_W-1:0]   curr_peak,
    output logic                is_idle,
    output logic                frame_swap,
    output logic [15:0]         frame_count
);

    sched_state_t      r_state;
    logic              r_disp_bank;
    logic              r_wr_ready;
    logic              r_is_idle;
    logic              r_frame_swap;
    logic [15:0]       r_frame_count;

    logic              r_s1_valid;
    logic              r_s1_last;
    logic              r_s1_inrange;
    logic [BIN_W-1:0]  r_s1_bin;
    logic [PEAK_W-1:0] r_s1_mag;

    logic              w_accept;
    logic [PEAK_W-1:0] w_clamped;
    logic [PEAK_W-1:0] w_hold_data;
    logic [PEAK_W-1:0] w_wr_data;

    assign w_accept  = wr_valid & r_wr_ready;
    assign w_clamped = clamp_mag(32'(wr_mag >> MAG_SHIFT), MAX_Y);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_last  <= w_accept & wr_last;
        end
    end

    always_ff @(posedge clk) begin
        r_s1_bin     <= wr_bin;
        r_s1_mag     <= w_clamped;
        r_s1_inrange <= (32'(wr_bin) < N_BINS);
    end

`ifdef PEAK_HOLD_EN
    // Old peak comes from the displayed bank, so the fill bank never aliases it.
    logic [PEAK_W-1:0] w_decayed;
    assign w_decayed = (w_hold_data > PEAK_W'(DECAY)) ? (w_hold_data - PEAK_W'(DECAY)) : '0;
    assign w_wr_data = (r_s1_mag > w_decayed) ? r_s1_mag : w_decayed;
`else
    logic w_unused_hold;
    assign w_unused_hold = (^w_hold_data) ^ (DECAY == 0);
    assign w_wr_data     = r_s1_mag;
`endif

    peak_bank_ram #(
        .N_BINS (N_BINS)
    ) u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (r_s1_valid & r_s1_inrange),
        .wr_bank   (~r_disp_bank),
        .wr_addr   (r_s1_bin),
        .wr_data   (w_wr_data),
        .rd_bank   (r_disp_bank),
        .rd_en     (32'(draw_x) < N_BINS),
        .rd_addr   (draw_x[BIN_W-1:0]),
        .rd_data   (curr_peak),
        .hold_addr (wr_bin),
        .hold_data (w_hold_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= FILL;
            r_disp_bank   <= 1'b0;
            r_wr_ready    <= 1'b0;
            r_is_idle     <= 1'b0;
            r_frame_swap  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_swap <= 1'b0;
            case (r_state)
                FILL: begin
                    // Leave FILL only once the last write has actually landed.
                    if (r_s1_valid && r_s1_last) begin
                        r_state    <= PENDING;
                        r_wr_ready <= 1'b0;
                    end else if (w_accept && wr_last) begin
                        r_wr_ready <= 1'b0;
                    end else begin
                        r_wr_ready <= 1'b1;
                    end
                end
                PENDING: begin
                    if (clear_state) begin
                        r_state       <= SWAP;
                        r_disp_bank   <= ~r_disp_bank;
                        r_frame_swap  <= 1'b1;
                        r_frame_count <= r_frame_count + 16'd1;
                    end
                end
                SWAP: begin
                    r_state   <= ARMED;
                    r_is_idle <= 1'b1;
                end
                ARMED: begin
                    if (draw_state) begin
                        r_state    <= FILL;
                        r_is_idle  <= 1'b0;
                        r_wr_ready <= 1'b1;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign wr_ready    = r_wr_ready;
    assign is_idle     = r_is_idle;
    assign frame_swap  = r_frame_swap;
    assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_spectrum_frame_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module    : tb_spectrum_frame_scheduler                                    |
// | Purpose   : Directed self-checking bench for spectrum_frame_scheduler.     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spectrum_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [8:0]  wr_bin = '0;
    logic [15:0] wr_mag = '0;
    logic        wr_last = 1'b0;
    logic        draw_state = 1'b0;
    logic        clear_state = 1'b0;
    logic [9:0]  draw_x = 10'd600;
    logic [8:0]  curr_peak;
    logic        is_idle;
    logic        frame_swap;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spectrum_frame_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_bin      (wr_bin),
        .wr_mag      (wr_mag),
        .wr_last     (wr_last),
        .draw_state  (draw_state),
        .clear_state (clear_state),
        .draw_x      (draw_x),
        .curr_peak   (curr_peak),
        .is_idle     (is_idle),
        .frame_swap  (frame_swap),
        .frame_count (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] bin, input logic [15:0] mag, input logic last);
        int n;
        wr_valid = 1'b1;
        wr_bin   = bin;
        wr_mag   = mag;
        wr_last  = last;
        n = 0;
        while (!wr_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("send_ready_timeout", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic wait_swap();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (frame_swap) got = 1'b1;
        end
        check("swap_seen", 32'(got), 32'd1);
    endtask

    task automatic peek(input string tag, input logic [9:0] x, input logic [8:0] exp);
        draw_x = x;
        tick();
        check(tag, 32'(curr_peak), 32'(exp));
    endtask

    task automatic start_draw();
        draw_state = 1'b1;
        tick();
        draw_state = 1'b0;
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_is_idle", 32'(is_idle), 32'd0);
        check("rst_frame_swap", 32'(frame_swap), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_curr_peak", 32'(curr_peak), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("ready_after_rst", 32'(wr_ready), 32'd1);

        // Frame 1: full ramp, clear_state low while frame completes
        for (int b = 0; b < 512; b++)
            send(9'(b), 16'(b << 6), b == 511);
        check("f1_ready_low", 32'(wr_ready), 32'd0);
        tick();
        draw_state = 1'b1;
        tick();
        draw_state = 1'b0;
        check("stray_draw_idle", 32'(is_idle), 32'd0);
        check("stray_draw_ready", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("pending_no_swap", 32'(frame_swap), 32'd0);
        check("pending_count", 32'(frame_count), 32'd0);
        check("pending_peak", 32'(curr_peak), 32'd0);
        clear_state = 1'b1;
        wait_swap();
        check("f1_count", 32'(frame_count), 32'd1);
        tick();
        check("f1_swap_pulse", 32'(frame_swap), 32'd0);
        check("f1_idle", 32'(is_idle), 32'd1);
        peek("f1_x100", 10'd100, 9'd100);
        peek("f1_x511_clamp", 10'd511, 9'd479);
        peek("f1_x3", 10'd3, 9'd3);
        peek("f1_x_oob", 10'd700, 9'd0);
        start_draw();
        check("draw_idle_low", 32'(is_idle), 32'd0);
        check("draw_ready_high", 32'(wr_ready), 32'd1);
        clear_state = 1'b0;

        // Frame 2: sparse bins, saturating magnitude
        send(9'd3, 16'hFFFF, 1'b0);
        send(9'd5, 16'(200 << 6), 1'b0);
        send(9'd188, 16'(300 << 6), 1'b1);
        tick();
        peek("f2_stable_x100", 10'd100, 9'd100);
        clear_state = 1'b1;
        wait_swap();
        check("f2_count", 32'(frame_count), 32'd2);
        peek("f2_x3_sat", 10'd3, 9'd479);
        peek("f2_x5", 10'd5, 9'd200);
        peek("f2_x188", 10'd188, 9'd300);
        check("f2_idle", 32'(is_idle), 32'd1);
        start_draw();

        // Frame 3: clear_state already high when the last sample lands
        send(9'd5, 16'd0, 1'b1);
        tick();
        check("f3_no_early_swap", 32'(frame_swap), 32'd0);
        wait_swap();
        check("f3_count", 32'(frame_count), 32'd3);
`ifdef PEAK_HOLD_EN
        peek("f3_x5_hold", 10'd5, 9'd196);
`else
        peek("f3_x5", 10'd5, 9'd0);
`endif
        peek("f3_x3_old", 10'd3, 9'd3);
        peek("f3_x100_old", 10'd100, 9'd100);
        start_draw();

        // Frame 4
        send(9'd5, 16'd0, 1'b1);
        wait_swap();
        check("f4_count", 32'(frame_count), 32'd4);
`ifdef PEAK_HOLD_EN
        peek("f4_x5_hold", 10'd5, 9'd192);
`else
        peek("f4_x5", 10'd5, 9'd0);
`endif
        peek("f4_x3_old", 10'd3, 9'd479);
        start_draw();

        // Asynchronous reset in the middle of a fill
        clear_state = 1'b0;
        send(9'd10, 16'd640, 1'b0);
        send(9'd11, 16'd640, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(wr_ready), 32'd0);
        check("mid_rst_idle", 32'(is_idle), 32'd0);
        check("mid_rst_swap", 32'(frame_swap), 32'd0);
        check("mid_rst_count", 32'(frame_count), 32'd0);
        check("mid_rst_peak", 32'(curr_peak), 32'd0);
        #3;
        reset_n = 1'b1;
        clear_state = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("post_rst_idle", 32'(is_idle), 32'd0);
        check("post_rst_count", 32'(frame_count), 32'd0);
        check("post_rst_ready", 32'(wr_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
